// File: rtl/four_bit_down_counter_pkg.sv
// Shared definitions for the loadable down-counter/timer.
//   DEFAULT_WIDTH : default counter width
//   state_e       : FSM state encoding (IDLE / RUN)
//   nand2()       : the single NAND primitive the decrementer is built from
package four_bit_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/four_bit_decrementer.sv
// Gate-level decrementer: diff = a - 1 (mod 2^WIDTH) as a half-subtractor
// chain with the first borrow-in tied high.
//   a_i            : operand
//   diff_o         : a_i - 1, wrapping
//   final_borrow_o : borrow out of the top bit (1 only when a_i == 0)
module four_bit_decrementer
  import four_bit_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             final_borrow_o
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic x_n1, x_n2, x_n3;
    logic a_n, and_n;

    // xor from four NANDs: diff = a ^ bin
    assign x_n1      = nand2(a_i[i], borrow[i]);
    assign x_n2      = nand2(a_i[i], x_n1);
    assign x_n3      = nand2(borrow[i], x_n1);
    assign diff_o[i] = nand2(x_n2, x_n3);

    // bout = ~a & bin, using NAND-as-inverter
    assign a_n           = nand2(a_i[i], a_i[i]);
    assign and_n         = nand2(a_n, borrow[i]);
    assign borrow[i+1]   = nand2(and_n, and_n);
  end

  assign final_borrow_o = borrow[WIDTH];

endmodule

// File: rtl/four_bit_down_counter.sv
// Loadable, pausable down-counter/timer with optional auto-reload.
//   clk_i      : clock, all state on posedge
//   rst_n_i    : synchronous active-low reset
//   load_i     : capture load_val_i and start (priority after reset)
//   load_val_i : start value
//   en_i       : count enable, 0 holds
//   abort_i    : stop counting, return to IDLE with count held
//   count_o    : registered count
//   busy_o     : high while in RUN
//   done_o     : one-cycle registered pulse when count first shows 0
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | not counting; count holds its last value
// ST_RUN  | counting down on enabled cycles
module four_bit_down_counter
  import four_bit_down_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] count_dec;
  logic             count_is_zero;

  // The borrow out of the chain is set exactly when the operand is zero,
  // so it doubles as the zero detect for the reload branch.
  four_bit_decrementer #(
    .WIDTH(WIDTH)
  ) u_dec (
    .a_i            (count_q),
    .diff_o         (count_dec),
    .final_borrow_o (count_is_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
      // A zero load is a zero-length timer: finish immediately, never run.
      if (load_val_i == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      if (abort_i) begin
        state_d = ST_IDLE;
      end else if (en_i) begin
        if (count_is_zero) begin
          // Only reachable with auto-reload; reload_q is never zero here.
          count_d = reload_q;
        end else begin
          count_d = count_dec;
          if (count_q == WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = AUTO_RELOAD ? ST_RUN : ST_IDLE;
          end
        end
      end
    end
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = done_q;

endmodule

// File: tb/tb_four_bit_down_counter.sv
module tb_four_bit_down_counter;

  logic       clk = 1'b0;
  logic       rst_n, load, en, abort;
  logic [3:0] load_val;
  logic [3:0] count0, count1;
  logic       busy0, busy1, done0, done1;
  logic [3:0] dec_a, dec_diff;
  logic       dec_b;

  always #5 clk = ~clk;

  four_bit_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .load_i(load), .load_val_i(load_val),
    .en_i(en), .abort_i(abort), .count_o(count0), .busy_o(busy0), .done_o(done0)
  );

  four_bit_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .load_i(load), .load_val_i(load_val),
    .en_i(en), .abort_i(abort), .count_o(count1), .busy_o(busy1), .done_o(done1)
  );

  four_bit_decrementer #(.WIDTH(4)) u_dec_chk (
    .a_i(dec_a), .diff_o(dec_diff), .final_borrow_o(dec_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: remaining ticks, running flag, reload value, done pulse.
  int m_cnt  [2];
  int m_rel  [2];
  bit m_run  [2];
  bit m_done [2];

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp))
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit auto_rl;
    bit nd;
    auto_rl = (i == 1);
    nd      = 1'b0;
    if (!rst_n) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0;
    end else begin
      if (load) begin
        m_cnt[i] = int'(load_val);
        m_rel[i] = int'(load_val);
        m_run[i] = (load_val != 0);
        nd       = (load_val == 0);
      end else if (m_run[i]) begin
        if (abort) m_run[i] = 1'b0;
        else if (en) begin
          if (m_cnt[i] == 0) m_cnt[i] = m_rel[i];
          else begin
            m_cnt[i] = m_cnt[i] - 1;
            if (m_cnt[i] == 0) begin
              nd       = 1'b1;
              m_run[i] = auto_rl;
            end
          end
        end
      end
      m_done[i] = nd;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check($sformatf("%s/count0", tag), 32'(count0), m_cnt[0]);
    check($sformatf("%s/busy0",  tag), 32'(busy0),  int'(m_run[0]));
    check($sformatf("%s/done0",  tag), 32'(done0),  int'(m_done[0]));
    check($sformatf("%s/count1", tag), 32'(count1), m_cnt[1]);
    check($sformatf("%s/busy1",  tag), 32'(busy1),  int'(m_run[1]));
    check($sformatf("%s/done1",  tag), 32'(done1),  int'(m_done[1]));
  endtask

  initial begin
    int exp_a[6];
    int exp_c[9];
    int done_cnt;

    rst_n = 1'b0; load = 1'b0; en = 1'b0; abort = 1'b0; load_val = 4'd0; dec_a = 4'd0;
    tick("reset");
    tick("reset");
    check("reset_count", 32'(count0), 0);
    check("reset_busy",  32'(busy0),  0);
    check("reset_done",  32'(done0),  0);

    // load 5, en held
    exp_a = '{5, 4, 3, 2, 1, 0};
    rst_n = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick("t5");
      load = 1'b0;
      check("t5_seq",  32'(count0), exp_a[k]);
      check("t5_done", 32'(done0),  (k == 5) ? 1 : 0);
      check("t5_busy", 32'(busy0),  (k < 5) ? 1 : 0);
    end
    en = 1'b0;
    tick("t5_after");

    // load 3 with en toggling
    load = 1'b1; load_val = 4'd3; en = 1'b1;
    tick("t3_load");
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      en = (k % 2 == 0);
      tick("t3_toggle");
    end
    check("t3_final", 32'(count0), 0);
    en = 1'b0;
    tick("t3_after");

    // auto-reload period 3
    exp_c = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
    load = 1'b1; load_val = 4'd2; en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick("ar");
      load = 1'b0;
      check("ar_seq",  32'(count1), exp_c[k]);
      check("ar_busy", 32'(busy1),  1);
      check("ar_done", 32'(done1),  (exp_c[k] == 0) ? 1 : 0);
    end
    abort = 1'b1; en = 1'b0;
    tick("ar_abort");
    abort = 1'b0;

    // zero-length timer
    load = 1'b1; load_val = 4'd0;
    tick("zero_load");
    load = 1'b0;
    check("zero_count", 32'(count0), 0);
    check("zero_busy",  32'(busy0),  0);
    check("zero_done",  32'(done0),  1);
    tick("zero_after");
    check("zero_done_clr", 32'(done0), 0);

    // full-range 15
    load = 1'b1; load_val = 4'hF; en = 1'b1;
    tick("f_load");
    load = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      tick("f_run");
      if (done0) done_cnt++;
    end
    check("f_done_once", 32'(done_cnt), 1);

    // abort at 6
    load = 1'b1; load_val = 4'd10; en = 1'b1;
    tick("ab_load");
    load = 1'b0;
    for (int k = 0; k < 4; k++) tick("ab_run");
    abort = 1'b1;
    tick("ab_abort");
    abort = 1'b0;
    check("ab_count", 32'(count0), 6);
    check("ab_busy",  32'(busy0),  0);
    check("ab_done",  32'(done0),  0);

    // reload at 6
    load = 1'b1; load_val = 4'd10;
    tick("rl_load");
    load = 1'b0;
    for (int k = 0; k < 4; k++) tick("rl_run");
    load = 1'b1; load_val = 4'd9;
    tick("rl_restart");
    load = 1'b0;
    check("rl_count", 32'(count0), 9);
    check("rl_busy",  32'(busy0),  1);

    // reset with load at 6
    for (int k = 0; k < 3; k++) tick("rs_run");
    rst_n = 1'b0; load = 1'b1; load_val = 4'd7;
    tick("rs_reset");
    rst_n = 1'b1; load = 1'b0;
    check("rs_count", 32'(count0), 0);
    check("rs_busy",  32'(busy0),  0);
    check("rs_done",  32'(done0),  0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      abort    = ($urandom_range(0, 29) == 0);
      tick("rand");
    end

    // decrementer exhaustive
    for (int a = 0; a < 16; a++) begin
      dec_a = 4'(a);
      #1;
      check("dec_diff",   32'(dec_diff), (a + 15) % 16);
      check("dec_borrow", 32'(dec_b),    (a == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
